// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flexible-depth FIFO.
package fifo_pkg;
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy must represent 0..size inclusive.
  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int ptr_w(input int size);
    return $clog2(size);
  endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-p_SIZE pointer; wraps explicitly so non-power-of-two depths work.
module fifo_wrap_ptr import fifo_pkg::*; #(
  parameter int p_SIZE = 8
)(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_inc,
  output logic [ptr_w(p_SIZE)-1:0] o_ptr
);
  localparam int W = ptr_w(p_SIZE);

  always_ff @(posedge i_clk) begin
    if (i_reset)      o_ptr <= '0;
    else if (i_inc)   o_ptr <= (o_ptr == W'(p_SIZE - 1)) ? '0 : o_ptr + W'(1);
  end
endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO: arbitrary depth, registered or FWFT read, count,
// threshold flags and sticky overflow/underflow.
module fifo_flex import fifo_pkg::*; #(
  parameter int p_WORD_LEN  = 8,
  parameter int p_FIFO_SIZE = 8,
  parameter int p_FWFT      = FIFO_MODE_REG,
  parameter int p_AF_LEVEL  = p_FIFO_SIZE - 1,
  parameter int p_AE_LEVEL  = 1
)(
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear_err,
  input  logic [p_WORD_LEN-1:0]         enq_data,
  input  logic                          enq_en,
  output logic                          enq_rdy,
  output logic [p_WORD_LEN-1:0]         deq_data,
  input  logic                          deq_en,
  output logic                          deq_rdy,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [cnt_w(p_FIFO_SIZE)-1:0] o_count,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic                          o_overflow,
  output logic                          o_underflow
);
  localparam int CW = cnt_w(p_FIFO_SIZE);
  localparam int PW = ptr_w(p_FIFO_SIZE);

  logic [p_WORD_LEN-1:0] mem [p_FIFO_SIZE];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_enq, do_deq;

  // Readies come from the registered count only; reset masks both handshakes.
  assign o_full         = (count == CW'(p_FIFO_SIZE));
  assign o_empty        = (count == '0);
  assign enq_rdy        = !o_full;
  assign deq_rdy        = !o_empty;
  assign o_count        = count;
  assign o_almost_full  = (count >= CW'(p_AF_LEVEL));
  assign o_almost_empty = (count <= CW'(p_AE_LEVEL));
  assign do_enq         = enq_en && enq_rdy && !i_reset;
  assign do_deq         = deq_en && deq_rdy && !i_reset;

  fifo_wrap_ptr #(.p_SIZE(p_FIFO_SIZE)) u_wr_ptr (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc(do_enq), .o_ptr(wr_ptr)
  );
  fifo_wrap_ptr #(.p_SIZE(p_FIFO_SIZE)) u_rd_ptr (
    .i_clk(i_clk), .i_reset(i_reset), .i_inc(do_deq), .o_ptr(rd_ptr)
  );

  always_ff @(posedge i_clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                 count <= '0;
    else if (do_enq && !do_deq)  count <= count + CW'(1);
    else if (do_deq && !do_enq)  count <= count - CW'(1);
  end

  // New error beats a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (enq_en && o_full)  || (o_overflow  && !i_clear_err);
      o_underflow <= (deq_en && o_empty) || (o_underflow && !i_clear_err);
    end
  end

  generate
    if (p_FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word shown directly; zero while empty so reset reads back 0.
      assign deq_data = deq_rdy ? mem[rd_ptr] : '0;
    end else begin : g_reg
      logic [p_WORD_LEN-1:0] rd_q;
      always_ff @(posedge i_clk) begin
        if (i_reset)     rd_q <= '0;
        else if (do_deq) rd_q <= mem[rd_ptr];
      end
      assign deq_data = rd_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench: three fifo_flex instances (depth 8 reg, depth 5 reg, depth 8 FWFT).
module tb_fifo_flex;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---- instance A: depth 8, registered read
  logic       a_rst = 1'b0, a_clr = 1'b0, a_enq = 1'b0, a_deq = 1'b0;
  logic [7:0] a_wd = '0, a_rd;
  logic       a_erdy, a_drdy, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [3:0] a_cnt;
  fifo_flex #(.p_WORD_LEN(8), .p_FIFO_SIZE(8), .p_FWFT(0)) u_a (
    .i_clk(i_clk), .i_reset(a_rst), .i_clear_err(a_clr),
    .enq_data(a_wd), .enq_en(a_enq), .enq_rdy(a_erdy),
    .deq_data(a_rd), .deq_en(a_deq), .deq_rdy(a_drdy),
    .o_full(a_full), .o_empty(a_empty), .o_count(a_cnt),
    .o_almost_full(a_af), .o_almost_empty(a_ae),
    .o_overflow(a_ov), .o_underflow(a_un));

  // ---- instance B: depth 5, registered read
  logic       b_rst = 1'b0, b_clr = 1'b0, b_enq = 1'b0, b_deq = 1'b0;
  logic [7:0] b_wd = '0, b_rd;
  logic       b_erdy, b_drdy, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [2:0] b_cnt;
  fifo_flex #(.p_WORD_LEN(8), .p_FIFO_SIZE(5), .p_FWFT(0)) u_b (
    .i_clk(i_clk), .i_reset(b_rst), .i_clear_err(b_clr),
    .enq_data(b_wd), .enq_en(b_enq), .enq_rdy(b_erdy),
    .deq_data(b_rd), .deq_en(b_deq), .deq_rdy(b_drdy),
    .o_full(b_full), .o_empty(b_empty), .o_count(b_cnt),
    .o_almost_full(b_af), .o_almost_empty(b_ae),
    .o_overflow(b_ov), .o_underflow(b_un));

  // ---- instance C: depth 8, FWFT
  logic       c_rst = 1'b0, c_clr = 1'b0, c_enq = 1'b0, c_deq = 1'b0;
  logic [7:0] c_wd = '0, c_rd;
  logic       c_erdy, c_drdy, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [3:0] c_cnt;
  fifo_flex #(.p_WORD_LEN(8), .p_FIFO_SIZE(8), .p_FWFT(1)) u_c (
    .i_clk(i_clk), .i_reset(c_rst), .i_clear_err(c_clr),
    .enq_data(c_wd), .enq_en(c_enq), .enq_rdy(c_erdy),
    .deq_data(c_rd), .deq_en(c_deq), .deq_rdy(c_drdy),
    .o_full(c_full), .o_empty(c_empty), .o_count(c_cnt),
    .o_almost_full(c_af), .o_almost_empty(c_ae),
    .o_overflow(c_ov), .o_underflow(c_un));

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Reset state
    check("a_rst_empty", 32'(a_empty), 32'd1);
    check("a_rst_full",  32'(a_full),  32'd0);
    check("a_rst_count", 32'(a_cnt),   32'd0);
    check("a_rst_ae",    32'(a_ae),    32'd1);
    check("a_rst_af",    32'(a_af),    32'd0);
    check("a_rst_ov",    32'(a_ov),    32'd0);
    check("a_rst_un",    32'(a_un),    32'd0);
    check("a_rst_data",  32'(a_rd),    32'd0);
    check("a_rst_erdy",  32'(a_erdy),  32'd1);
    check("a_rst_drdy",  32'(a_drdy),  32'd0);

    // Fill 0x11..0x18; almost_full from count 7, almost_empty up to count 1
    a_enq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_wd = 8'(8'h11 + i);
      tick();
      check("a_fill_count", 32'(a_cnt), 32'(i + 1));
      check("a_fill_af",    32'(a_af),  32'((i + 1) >= 7));
      check("a_fill_ae",    32'(a_ae),  32'((i + 1) <= 1));
    end
    a_enq = 1'b0;
    check("a_full",      32'(a_full), 32'd1);
    check("a_full_erdy", 32'(a_erdy), 32'd0);

    // Drain: each word valid the cycle after its pop
    a_deq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("a_drain_data",  32'(a_rd),  32'(8'h11 + i));
      check("a_drain_count", 32'(a_cnt), 32'(7 - i));
    end
    a_deq = 1'b0;
    check("a_drain_empty", 32'(a_empty), 32'd1);
    check("a_drain_un",    32'(a_un),    32'd0);

    // Full with simultaneous enq/deq: dequeue proceeds, enqueue refused
    a_enq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_wd = 8'(8'h21 + i);
      tick();
    end
    a_wd = 8'h99; a_deq = 1'b1;
    tick();
    a_enq = 1'b0; a_deq = 1'b0;
    check("a_both_count", 32'(a_cnt), 32'd7);
    check("a_both_ov",    32'(a_ov),  32'd1);
    check("a_both_data",  32'(a_rd),  32'h21);
    tick();
    check("a_ov_sticky",  32'(a_ov),  32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("a_ov_cleared", 32'(a_ov),  32'd0);
    a_deq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("a_after_ov_data", 32'(a_rd), 32'(8'h22 + i));
    end
    a_deq = 1'b0;
    check("a_after_ov_empty", 32'(a_empty), 32'd1);

    // Underflow: two pops on empty change nothing but the flag
    a_deq = 1'b1;
    tick(); tick();
    a_deq = 1'b0;
    check("a_un_flag",  32'(a_un),    32'd1);
    check("a_un_empty", 32'(a_empty), 32'd1);
    check("a_un_count", 32'(a_cnt),   32'd0);
    check("a_un_data",  32'(a_rd),    32'h28);
    a_enq = 1'b1; a_wd = 8'h55;
    tick();
    a_enq = 1'b0; a_deq = 1'b1;
    tick();
    a_deq = 1'b0;
    check("a_un_next_data", 32'(a_rd), 32'h55);
    check("a_un_still",     32'(a_un), 32'd1);

    // Clear coinciding with a new underflow: set wins
    a_clr = 1'b1; a_deq = 1'b1;
    tick();
    a_clr = 1'b0; a_deq = 1'b0;
    check("a_set_wins", 32'(a_un), 32'd1);

    // Mid-operation reset with enq_en high
    a_enq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_wd = 8'(8'h61 + i);
      tick();
    end
    check("a_pre_rst_count", 32'(a_cnt), 32'd4);
    a_wd = 8'h77; a_rst = 1'b1;
    tick();
    a_rst = 1'b0; a_enq = 1'b0;
    check("a_mrst_count", 32'(a_cnt),   32'd0);
    check("a_mrst_empty", 32'(a_empty), 32'd1);
    check("a_mrst_data",  32'(a_rd),    32'd0);
    check("a_mrst_ae",    32'(a_ae),    32'd1);
    check("a_mrst_af",    32'(a_af),    32'd0);
    check("a_mrst_un",    32'(a_un),    32'd0);
    check("a_mrst_ov",    32'(a_ov),    32'd0);
    a_enq = 1'b1; a_wd = 8'h88;
    tick();
    a_enq = 1'b0;
    check("a_post_rst_count", 32'(a_cnt), 32'd1);
    a_deq = 1'b1;
    tick();
    a_deq = 1'b0;
    check("a_post_rst_data", 32'(a_rd), 32'h88);

    // Depth-5 wrap: three fill/drain rounds, data 0..14
    for (int r = 0; r < 3; r++) begin
      b_enq = 1'b1;
      for (int i = 0; i < 5; i++) begin
        b_wd = 8'(r * 5 + i);
        tick();
      end
      b_enq = 1'b0;
      check("b_peak_count", 32'(b_cnt),  32'd5);
      check("b_peak_full",  32'(b_full), 32'd1);
      b_deq = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("b_wrap_data", 32'(b_rd), 32'(r * 5 + i));
      end
      b_deq = 1'b0;
      check("b_round_empty", 32'(b_empty), 32'd1);
    end
    check("b_no_ov", 32'(b_ov), 32'd0);
    check("b_no_un", 32'(b_un), 32'd0);

    // FWFT latency
    check("c_rst_drdy", 32'(c_drdy), 32'd0);
    c_enq = 1'b1; c_wd = 8'hA5;
    tick();
    c_enq = 1'b0;
    check("c_fwft_drdy",  32'(c_drdy), 32'd1);
    check("c_fwft_data",  32'(c_rd),   32'hA5);
    check("c_fwft_count", 32'(c_cnt),  32'd1);
    c_enq = 1'b1; c_wd = 8'h3C; c_deq = 1'b1;
    tick();
    c_enq = 1'b0; c_deq = 1'b0;
    check("c_swap_count", 32'(c_cnt), 32'd1);
    check("c_swap_data",  32'(c_rd),  32'h3C);
    c_enq = 1'b1;
    c_wd = 8'h01; tick();
    c_wd = 8'h02; tick();
    c_enq = 1'b0;
    check("c_head_hold", 32'(c_rd), 32'h3C);
    c_deq = 1'b1;
    tick();
    check("c_next_01", 32'(c_rd), 32'h01);
    tick();
    check("c_next_02", 32'(c_rd), 32'h02);
    tick();
    c_deq = 1'b0;
    check("c_end_empty", 32'(c_empty), 32'd1);
    check("c_end_un",    32'(c_un),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
